qspi_master_param: RTL and testbench

Parametrised quad-capable SPI master for the external flash/peripheral interface. It supports single, dual and quad lane modes, selected per transfer. It generates a divided serial clock instead of forwarding the system clock, and it drives multiple chip selects. A start/busy/done handshake carries one DATA_W-bit full-duplex transfer per start.

---
 rtl/qspi_master_param.sv | 156 +++++++++++++++
 tb/tb_qspi_master_param.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/qspi_master_param.sv
// SPI master with single/dual/quad lanes, divided sclk (CPOL=0, CPHA=0) and
// decoded active-low chip selects; one DATA_W-bit full-duplex transfer per start.
module qspi_master_param #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2,
  parameter int NUM_CS  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [1:0]                mode,
  input  logic [$clog2(NUM_CS):0]   cs_sel,
  input  logic [DATA_W-1:0]         tx_data,
  output logic [DATA_W-1:0]         rx_data,
  output logic                      busy,
  output logic                      done,
  output logic                      sclk,
  output logic [NUM_CS-1:0]         cs_n,
  output logic [3:0]                mosi,
  input  logic [3:0]                miso
);

  localparam int SW = $clog2(NUM_CS) + 1;
  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST   = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] ALL_BITS = BW'(DATA_W);

  typedef enum logic [2:0] {IDLE, LOW, HIGH, TRAIL, DONE} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [BW-1:0]       bits;
  logic [1:0]          mode_q;
  logic [DATA_W-1:0]   tx_sh;
  logic [DATA_W-1:0]   rx_sh;

  function automatic logic [BW-1:0] lanes(input logic [1:0] m);
    case (m)
      2'd0:    return BW'(1);
      2'd1:    return BW'(2);
      default: return BW'(4);
    endcase
  endfunction

  // Current beat taken from the MSB end; lanes above L stay 0.
  function automatic logic [3:0] lane_out(input logic [DATA_W-1:0] d, input logic [1:0] m);
    logic [3:0] r;
    r = 4'h0;
    case (m)
      2'd0:    r[0]   = d[DATA_W-1];
      2'd1:    r[1:0] = d[DATA_W-1 -: 2];
      default: r      = d[DATA_W-1 -: 4];
    endcase
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] r,
                                                 input logic [3:0] mi,
                                                 input logic [1:0] m);
    case (m)
      2'd0:    return (r << 1) | DATA_W'(mi[0]);
      2'd1:    return (r << 2) | DATA_W'(mi[1:0]);
      default: return (r << 4) | DATA_W'(mi);
    endcase
  endfunction

  // An out-of-range select leaves every chip select deasserted.
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [SW-1:0] sel);
    logic [NUM_CS-1:0] r;
    r = '1;
    for (int i = 0; i < NUM_CS; i++)
      if (sel == SW'(i)) r[i] = 1'b0;
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bits    <= '0;
      mode_q  <= 2'd0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      rx_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sclk    <= 1'b0;
      cs_n    <= '1;
      mosi    <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            tx_sh  <= tx_data;
            rx_sh  <= '0;
            mode_q <= mode;
            cs_n   <= cs_decode(cs_sel);
            mosi   <= lane_out(tx_data, mode);
            sclk   <= 1'b0;
            busy   <= 1'b1;
            bits   <= '0;
            cnt    <= '0;
            state  <= LOW;
          end
        end
        LOW: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            sclk  <= 1'b1;
            rx_sh <= rx_shift(rx_sh, miso, mode_q);
            tx_sh <= tx_sh << lanes(mode_q);
            bits  <= bits + lanes(mode_q);
            state <= HIGH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HIGH: begin
          if (cnt == LAST) begin
            cnt  <= '0;
            sclk <= 1'b0;
            if (bits == ALL_BITS) begin
              mosi  <= 4'h0;
              state <= TRAIL;
            end else begin
              mosi  <= lane_out(tx_sh, mode_q);
              state <= LOW;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        TRAIL: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            cs_n    <= '1;
            done    <= 1'b1;
            rx_data <= rx_sh;
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_master_param.sv
// Directed bench for qspi_master_param (DATA_W=8, CLK_DIV=2, NUM_CS=2).
module tb_qspi_master_param;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [1:0] mode;
  logic [1:0] cs_sel;
  logic [7:0] tx_data, rx_data;
  logic       busy, done, sclk;
  logic [1:0] cs_n;
  logic [3:0] mosi, miso;

  int total = 0;
  int bad   = 0;

  qspi_master_param #(.DATA_W(8), .CLK_DIV(2), .NUM_CS(2)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .cs_sel(cs_sel),
    .tx_data(tx_data), .rx_data(rx_data), .busy(busy), .done(done),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mo/mi hold one nibble per beat, beat 0 in bits [31:28].
  task automatic run_xfer(input string nm, input logic [1:0] m, input logic [1:0] cs,
                          input logic [7:0] tx, input int nb, input logic [31:0] mo,
                          input logic [31:0] mi, input logic [1:0] exp_cs,
                          input logic [7:0] exp_rx);
    int   rises;
    logic prev;
    mode = m; cs_sel = cs; tx_data = tx; start = 1'b1; miso = mi[31 -: 4];
    tick;
    start = 1'b0; mode = ~m; tx_data = ~tx; cs_sel = ~cs;
    check({nm, " busy_at_start"}, {31'b0, busy}, 32'd1);
    check({nm, " cs_n_at_start"}, {30'b0, cs_n}, {30'b0, exp_cs});
    rises = 0;
    prev  = sclk;
    for (int c = 1; c <= 4 * nb + 2; c++) begin
      miso = (c <= 4 * nb) ? mi[31 - 4 * ((c - 1) / 4) -: 4] : 4'h0;
      tick;
      if (sclk && !prev) rises++;
      prev = sclk;
      if ((c % 4 == 1) && (c < 4 * nb))
        check($sformatf("%s mosi_beat%0d", nm, c / 4), {28'b0, mosi}, {28'b0, mo[31 - 4 * (c / 4) -: 4]});
      if (c == 4 * nb + 1) begin
        check({nm, " trail_mosi"}, {28'b0, mosi}, 32'd0);
        check({nm, " trail_done"}, {31'b0, done}, 32'd0);
        check({nm, " trail_cs_n"}, {30'b0, cs_n}, {30'b0, exp_cs});
      end
    end
    check({nm, " done"}, {31'b0, done}, 32'd1);
    check({nm, " rx_data"}, {24'b0, rx_data}, {24'b0, exp_rx});
    check({nm, " done_cs_n"}, {30'b0, cs_n}, 32'd3);
    check({nm, " done_busy"}, {31'b0, busy}, 32'd1);
    check({nm, " sclk_pulses"}, rises, nb);
    tick;
    check({nm, " idle_busy"}, {31'b0, busy}, 32'd0);
    check({nm, " idle_done"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int ndone, d0, d1, cs_low, b11, b12, late_done;
    reset = 1'b1; start = 1'b0; mode = 2'd0; cs_sel = 2'd0; tx_data = 8'h00; miso = 4'h0;
    tick; tick;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_sclk", {31'b0, sclk}, 32'd0);
    check("rst_cs_n", {30'b0, cs_n}, 32'd3);
    check("rst_mosi", {28'b0, mosi}, 32'd0);
    check("rst_rx",   {24'b0, rx_data}, 32'd0);
    reset = 1'b0;
    tick;

    run_xfer("quad",   2'd2, 2'd0, 8'hA5, 2, 32'hA500_0000, 32'h3C00_0000, 2'b10, 8'h3C);
    run_xfer("single", 2'd0, 2'd1, 8'h81, 8, 32'h1000_0001, 32'h0101_1010, 2'b01, 8'h5A);
    run_xfer("dual",   2'd1, 2'd0, 8'hE4, 4, 32'h3210_0000, 32'h0123_0000, 2'b10, 8'h1B);

    // Start held high across a whole transfer with an out-of-range select.
    mode = 2'd2; cs_sel = 2'd2; tx_data = 8'hFF; miso = 4'h0; start = 1'b1;
    ndone = 0; d0 = -1; d1 = -1; cs_low = 0; b11 = -1; b12 = -1;
    tick;
    for (int c = 1; c < 40; c++) begin
      if (c == 20) start = 1'b0;
      tick;
      if (cs_n != 2'b11) cs_low++;
      if (done) begin
        if (ndone == 0) d0 = c; else if (ndone == 1) d1 = c;
        ndone++;
      end
      if (c == 11) b11 = busy;
      if (c == 12) b12 = busy;
    end
    check("busy_start ndone", ndone, 2);
    check("busy_start first_done", d0, 10);
    check("busy_start second_done", d1, 22);
    check("busy_start cs_n_low_cycles", cs_low, 0);
    check("busy_start gap_idle", b11, 0);
    check("busy_start restart_busy", b12, 1);

    // Reset during the first sclk-high phase of a transfer.
    run_xfer("pre_reset", 2'd2, 2'd1, 8'h3C, 2, 32'h3C00_0000, 32'h7E00_0000, 2'b01, 8'h7E);
    mode = 2'd2; cs_sel = 2'd0; tx_data = 8'h5A; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    check("mid sclk_high", {31'b0, sclk}, 32'd1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("mid_rst sclk", {31'b0, sclk}, 32'd0);
    check("mid_rst cs_n", {30'b0, cs_n}, 32'd3);
    check("mid_rst busy", {31'b0, busy}, 32'd0);
    check("mid_rst rx",   {24'b0, rx_data}, 32'd0);
    check("mid_rst mosi", {28'b0, mosi}, 32'd0);
    late_done = 0;
    for (int c = 0; c < 15; c++) begin
      tick;
      if (done || busy) late_done++;
    end
    check("mid_rst no_done", late_done, 0);
    run_xfer("post_reset", 2'd1, 2'd1, 8'hE4, 4, 32'h3210_0000, 32'h0123_0000, 2'b01, 8'h1B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
